// File: rtl/wb_trace_checker_pkg.sv
// Shared definitions for the write-back trace checker: FSM encoding,
// default watch mask and trace-entry width helper.
package wb_trace_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    // r0 is hard-wired zero in the core, so it is never worth watching
    localparam logic [31:0] DEFAULT_WATCH_MASK = 32'hFFFF_FFFE;

    function automatic int entry_w(input int reg_aw, input int data_w);
        return reg_aw + data_w;
    endfunction

endpackage

// File: rtl/wb_trace_checker_trace_mem.sv
// Expected-trace storage: one synchronous write port, one asynchronous read
// port so the current entry is compared in the same cycle as the write-back.
module trace_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Trace load port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_trace_checker.sv
// Register-file write-back monitor: compares watched writes against a loaded
// {reg, value} trace and reports pass, mismatch or timeout with diagnostics.
module wb_trace_checker
    import wb_trace_checker_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          REG_AW     = 5,
    parameter int          DEPTH      = 64,
    parameter int          TIMEOUT    = 1024,
    parameter logic [31:0] WATCH_MASK = DEFAULT_WATCH_MASK
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_we,
    input  logic [$clog2(DEPTH)-1:0]         ld_addr,
    input  logic [REG_AW+DATA_W-1:0]         ld_data,
    input  logic                             start,
    input  logic [$clog2(DEPTH):0]           trace_len,
    input  logic                             wb_we,
    input  logic [REG_AW-1:0]                wb_waddr,
    input  logic [DATA_W-1:0]                wb_wdata,
    output logic                             busy,
    output logic                             pass,
    output logic                             fail,
    output logic                             timeout,
    output logic                             overrun,
    output logic [$clog2(DEPTH):0]           match_cnt,
    output logic [$clog2(TIMEOUT):0]         cycle_cnt,
    output logic [$clog2(DEPTH)-1:0]         err_idx,
    output logic [REG_AW-1:0]                err_reg,
    output logic [DATA_W-1:0]                err_data
);

    localparam int ENTRY_W = entry_w(REG_AW, DATA_W);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEN_W   = PTR_W + 1;
    localparam int CYC_W   = $clog2(TIMEOUT) + 1;
    localparam int NREG    = 2 ** REG_AW;
    localparam logic [NREG-1:0] WATCH_EFF = NREG'(WATCH_MASK) & ~(NREG'(1));

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic [PTR_W-1:0]   err_idx_q, err_idx_d;
    logic [REG_AW-1:0]  err_reg_q, err_reg_d;
    logic [DATA_W-1:0]  err_data_q, err_data_d;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;

    logic [ENTRY_W-1:0] exp_entry_s;
    logic               mem_we_s;
    logic               wb_hit_s;
    logic               entry_eq_s;
    logic               last_s;
    logic               limit_s;

    assign mem_we_s = ld_we && (state_q == ST_IDLE);

    trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trace_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (ptr_q),
        .rdata (exp_entry_s)
    );

    assign wb_hit_s   = wb_we && WATCH_EFF[wb_waddr] && (wb_waddr != REG_AW'(0));
    assign entry_eq_s = ({wb_waddr, wb_wdata} == exp_entry_s);
    assign last_s     = (LEN_W'(ptr_q) == (len_q - LEN_W'(1)));
    assign limit_s    = (cycle_cnt_q == CYC_W'(TIMEOUT - 1));

    // Next-state, counter and diagnostic capture logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        match_cnt_d = match_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;
        err_idx_d   = err_idx_q;
        err_reg_d   = err_reg_q;
        err_data_d  = err_data_q;

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    ptr_d       = PTR_W'(0);
                    match_cnt_d = LEN_W'(0);
                    cycle_cnt_d = CYC_W'(0);
                    overrun_d   = 1'b0;
                    timeout_d   = 1'b0;
                    err_idx_d   = PTR_W'(0);
                    err_reg_d   = REG_AW'(0);
                    err_data_d  = DATA_W'(0);
                    len_d       = trace_len;
                    state_d     = (trace_len == LEN_W'(0)) ? ST_PASS : ST_RUN;
                end else if ((state_q == ST_PASS) && wb_hit_s) begin
                    overrun_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
                // Mismatch beats final match, which beats timeout
                if (wb_hit_s && !entry_eq_s) begin
                    state_d    = ST_FAIL;
                    err_idx_d  = ptr_q;
                    err_reg_d  = wb_waddr;
                    err_data_d = wb_wdata;
                end else if (wb_hit_s) begin
                    ptr_d       = ptr_q + PTR_W'(1);
                    match_cnt_d = match_cnt_q + LEN_W'(1);
                    if (last_s) begin
                        state_d = ST_PASS;
                    end else if (limit_s) begin
                        state_d   = ST_FAIL;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (limit_s) begin
                    state_d   = ST_FAIL;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        pass_d = (state_d == ST_PASS);
        fail_d = (state_d == ST_FAIL);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_W'(0);
            len_q       <= LEN_W'(0);
            match_cnt_q <= LEN_W'(0);
            cycle_cnt_q <= CYC_W'(0);
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            err_idx_q   <= PTR_W'(0);
            err_reg_q   <= REG_AW'(0);
            err_data_q  <= DATA_W'(0);
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            match_cnt_q <= match_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            err_idx_q   <= err_idx_d;
            err_reg_q   <= err_reg_d;
            err_data_q  <= err_data_d;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;
    assign match_cnt = match_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
    assign err_idx   = err_idx_q;
    assign err_reg   = err_reg_q;
    assign err_data  = err_data_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Self-checking bench for wb_trace_checker: table-driven branch-test trace
// through a scoreboard queue, plus hand sequences for timing corner cases.
module tb_wb_trace_checker;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int PTR_W   = 3;
    localparam int LEN_W   = 4;
    localparam int CYC_W   = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     ld_we;
    logic [PTR_W-1:0]         ld_addr;
    logic [REG_AW+DATA_W-1:0] ld_data;
    logic                     start;
    logic [LEN_W-1:0]         trace_len;
    logic                     wb_we;
    logic [REG_AW-1:0]        wb_waddr;
    logic [DATA_W-1:0]        wb_wdata;
    logic                     busy, pass, fail, timeout, overrun;
    logic [LEN_W-1:0]         match_cnt;
    logic [CYC_W-1:0]         cycle_cnt;
    logic [PTR_W-1:0]         err_idx;
    logic [REG_AW-1:0]        err_reg;
    logic [DATA_W-1:0]        err_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             busy;
        logic             pass;
        logic             fail;
        logic [LEN_W-1:0] mc;
    } exp_t;

    typedef struct {
        logic              we;
        logic [REG_AW-1:0] a;
        logic [DATA_W-1:0] d;
        exp_t              e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];

    // r2 is left out of the watch mask so writes to it act as noise
    wb_trace_checker #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT),
        .WATCH_MASK (32'hFFFF_FFFA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .trace_len (trace_len),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .busy      (busy),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .overrun   (overrun),
        .match_cnt (match_cnt),
        .cycle_cnt (cycle_cnt),
        .err_idx   (err_idx),
        .err_reg   (err_reg),
        .err_data  (err_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [REG_AW-1:0] a,
                                input logic [DATA_W-1:0] d, input logic b,
                                input logic p, input logic f, input logic [LEN_W-1:0] mc);
        vec_t v;
        v.we = we; v.a = a; v.d = d;
        v.e.busy = b; v.e.pass = p; v.e.fail = f; v.e.mc = mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] v);
        ld_we   = 1'b1;
        ld_addr = PTR_W'(idx);
        ld_data = {r, v};
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic start_run(input int len);
        start     = 1'b1;
        trace_len = LEN_W'(len);
        tick();
        start     = 1'b0;
    endtask

    task automatic wr(input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        tick();
        wb_we    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_fail"}, 64'(fail), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
        chk({tag, "_match_cnt"}, 64'(match_cnt), 64'd0);
        chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        chk({tag, "_err_idx"}, 64'(err_idx), 64'd0);
        chk({tag, "_err_reg"}, 64'(err_reg), 64'd0);
        chk({tag, "_err_data"}, 64'(err_data), 64'd0);
    endtask

    task automatic load_branch_trace();
        load(0, 5'd1, 32'h1);
        load(1, 5'd3, 32'h3);
        load(2, 5'd1, 32'h11);
        load(3, 5'd31, 32'h40);
        load(4, 5'd3, 32'h7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;

        rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; trace_len = '0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;

        // Branch-test stream: in-order matches with r2 and r0 noise
        vecs[0] = mk(1'b1, 5'd1,  32'h1,  1'b1, 1'b0, 1'b0, 4'd1);
        vecs[1] = mk(1'b1, 5'd2,  32'h99, 1'b1, 1'b0, 1'b0, 4'd1);
        vecs[2] = mk(1'b1, 5'd3,  32'h3,  1'b1, 1'b0, 1'b0, 4'd2);
        vecs[3] = mk(1'b1, 5'd0,  32'h11, 1'b1, 1'b0, 1'b0, 4'd2);
        vecs[4] = mk(1'b0, 5'd1,  32'h11, 1'b1, 1'b0, 1'b0, 4'd2);
        vecs[5] = mk(1'b1, 5'd1,  32'h11, 1'b1, 1'b0, 1'b0, 4'd3);
        vecs[6] = mk(1'b1, 5'd31, 32'h40, 1'b1, 1'b0, 1'b0, 4'd4);
        vecs[7] = mk(1'b1, 5'd3,  32'h7,  1'b0, 1'b1, 1'b0, 4'd5);
        vecs[8] = mk(1'b0, 5'd3,  32'h7,  1'b0, 1'b1, 1'b0, 4'd5);

        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;

        load_branch_trace();
        start_run(5);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_cycle_cnt", 64'(cycle_cnt), 64'd0);

        for (int i = 0; i < 9; i++) begin
            wb_we    = vecs[i].we;
            wb_waddr = vecs[i].a;
            wb_wdata = vecs[i].d;
            sb_q.push_back(vecs[i].e);
            tick();
            wb_we = 1'b0;
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(e.busy));
            chk($sformatf("vec%0d_pass", i), 64'(pass), 64'(e.pass));
            chk($sformatf("vec%0d_fail", i), 64'(fail), 64'(e.fail));
            chk($sformatf("vec%0d_match_cnt", i), 64'(match_cnt), 64'(e.mc));
        end
        chk("branch_cycle_cnt", 64'(cycle_cnt), 64'd8);
        chk("branch_timeout", 64'(timeout), 64'd0);
        chk("branch_overrun", 64'(overrun), 64'd0);

        // Overrun in PASS, then restart with an empty trace
        wr(5'd1, 32'h5);
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("overrun_pass", 64'(pass), 64'd1);
        start_run(0);
        chk("len0_pass", 64'(pass), 64'd1);
        chk("len0_overrun", 64'(overrun), 64'd0);
        chk("len0_match_cnt", 64'(match_cnt), 64'd0);
        chk("len0_busy", 64'(busy), 64'd0);

        // Fourth write carries the wrong value
        start_run(5);
        wr(5'd1, 32'h1); wr(5'd3, 32'h3); wr(5'd1, 32'h11);
        chk("mm_pre_fail", 64'(fail), 64'd0);
        chk("mm_pre_busy", 64'(busy), 64'd1);
        wr(5'd31, 32'h44);
        chk("mm_fail", 64'(fail), 64'd1);
        chk("mm_err_idx", 64'(err_idx), 64'd3);
        chk("mm_err_reg", 64'(err_reg), 64'd31);
        chk("mm_err_data", 64'(err_data), 64'h44);
        chk("mm_match_cnt", 64'(match_cnt), 64'd3);
        chk("mm_timeout", 64'(timeout), 64'd0);

        // Timeout: len 3, only two matches arrive
        start_run(3);
        wr(5'd1, 32'h1); wr(5'd3, 32'h3);
        n = 0;
        while (!fail && n < 40) begin
            tick();
            n++;
        end
        chk("to_wait_cycles", 64'(n), 64'd14);
        chk("to_fail", 64'(fail), 64'd1);
        chk("to_timeout", 64'(timeout), 64'd1);
        chk("to_cycle_cnt", 64'(cycle_cnt), 64'd16);
        chk("to_match_cnt", 64'(match_cnt), 64'd2);

        // Final match on the last allowed cycle wins over timeout
        start_run(5);
        wr(5'd1, 32'h1); wr(5'd3, 32'h3); wr(5'd1, 32'h11); wr(5'd31, 32'h40);
        idle(11);
        chk("edge_pass_cycle_pre", 64'(cycle_cnt), 64'd15);
        chk("edge_pass_busy_pre", 64'(busy), 64'd1);
        wr(5'd3, 32'h7);
        chk("edge_pass", 64'(pass), 64'd1);
        chk("edge_pass_timeout", 64'(timeout), 64'd0);
        chk("edge_pass_cycle_cnt", 64'(cycle_cnt), 64'd16);
        chk("edge_pass_match_cnt", 64'(match_cnt), 64'd5);

        // Mismatch on the last allowed cycle is reported as a mismatch
        start_run(5);
        wr(5'd1, 32'h1); wr(5'd3, 32'h3); wr(5'd1, 32'h11); wr(5'd31, 32'h40);
        idle(11);
        wr(5'd3, 32'h8);
        chk("edge_mm_fail", 64'(fail), 64'd1);
        chk("edge_mm_timeout", 64'(timeout), 64'd0);
        chk("edge_mm_err_idx", 64'(err_idx), 64'd4);
        chk("edge_mm_err_data", 64'(err_data), 64'h8);

        // Reset mid-RUN; a load attempted during RUN must be ignored
        start_run(5);
        wr(5'd1, 32'h1); wr(5'd3, 32'h3);
        load(2, 5'd9, 32'hDEAD);
        chk("mid_match_cnt", 64'(match_cnt), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        start_run(3);
        wr(5'd1, 32'h1); wr(5'd3, 32'h3); wr(5'd1, 32'h11);
        chk("ldrun_ignored_pass", 64'(pass), 64'd1);

        // Reload from IDLE with a new trace and run to completion
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load(0, 5'd5, 32'hA5);
        load(1, 5'd6, 32'hB6);
        start_run(2);
        wr(5'd5, 32'hA5);
        chk("reload_mid_busy", 64'(busy), 64'd1);
        wr(5'd6, 32'hB6);
        chk("reload_pass", 64'(pass), 64'd1);
        chk("reload_match_cnt", 64'(match_cnt), 64'd2);
        chk("reload_fail", 64'(fail), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Synthesizable, parametrised self-checking monitor for the CPU instruction tests. It sits beside the core, snoops the register-file write-back port, and compares every write to a watched register against an expected trace of {register, value} entries. It reports pass, mismatch or timeout with diagnostics, so per-instruction benches no longer rely on waveform dumps and a fixed run length.

## Interface
Parameters:
- DATA_W, 32, write-back data width
- REG_AW, 5, register address width
- DEPTH, 64, max trace entries (power of two, ≥2)
- TIMEOUT, 1024, max cycles in RUN before failing
- WATCH_MASK, 32'hFFFF_FFFE, bit r set → writes to register r are checked (bit 0 forced off)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ld_we  in  1  trace load strobe (honoured in IDLE only)
- ld_addr  in  log2(DEPTH)  trace entry index
- ld_data  in  REG_AW+DATA_W  entry {reg, value}, reg in MSBs
- start  in  1  begin checking (honoured in IDLE, PASS, FAIL)
- trace_len  in  log2(DEPTH)+1  entries to match, sampled on start
- wb_we  in  1  core register-file write enable
- wb_waddr  in  REG_AW  core write address
- wb_wdata  in  DATA_W  core write data
- busy  out  1  state is RUN
- pass  out  1  state is PASS
- fail  out  1  state is FAIL
- timeout  out  1  FAIL caused by timeout
- overrun  out  1  sticky: watched write seen while in PASS
- match_cnt  out  log2(DEPTH)+1  entries matched so far
- cycle_cnt  out  log2(TIMEOUT)+1  cycles spent in RUN
- err_idx  out  log2(DEPTH)  trace index of first mismatch
- err_reg  out  REG_AW  offending write address
- err_data  out  DATA_W  offending write data

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE; every output 0; trace memory contents not cleared.
- IDLE: ld_we writes mem[ld_addr] ← ld_data. ld_we outside IDLE is ignored.
- start: ptr, match_cnt, cycle_cnt, overrun, timeout, err_* cleared; len ← trace_len. len = 0 → PASS, else → RUN.
- RUN, watched write (wb_we, WATCH_MASK[wb_waddr], wb_waddr ≠ 0):
  - {wb_waddr, wb_wdata} == mem[ptr] → ptr++, match_cnt++; if ptr == len-1 → PASS.
  - otherwise → FAIL; err_idx ← ptr, err_reg ← wb_waddr, err_data ← wb_wdata.
- Unwatched writes and writes to r0 are ignored in every state.
- RUN, per cycle: cycle_cnt++. When cycle_cnt == TIMEOUT-1 and that cycle neither matches the last entry nor mismatches → FAIL, timeout ← 1.
- Priority in one cycle: mismatch > final match (PASS) > timeout.
- PASS: watched write → overrun ← 1 (sticky); pass stays 1.
- PASS/FAIL hold until start or rst. start in RUN is ignored.
- rst in any state, including mid-RUN, returns to IDLE within one cycle and discards the verdict.

## Timing
- Trace memory: synchronous write, asynchronous read of mem[ptr]. A compare uses the same-cycle wb_* inputs.
- Verdict latency: pass/fail/err_* are registered and visible the cycle after the deciding write-back edge.
- A load on cycle N is readable from cycle N+1. start may be asserted on the cycle after the last ld_we.
- cycle_cnt counts RUN cycles, including the deciding cycle, and freezes in PASS/FAIL.
- Back-to-back watched writes, one per cycle, are all checked without stall.

## Structure
- Shared defines header: state encodings, entry-width macro (REG_AW+DATA_W), default WATCH_MASK.
- Sub-module trace_mem: DEPTH × (REG_AW+DATA_W), one synchronous write port, one asynchronous read port.
- Top-level logic (FSM, counters, capture registers) stays in wb_trace_checker. Target size is about 200 lines.

## Test plan
- Branch-test trace {r1=0x1, r3=0x3, r1=0x11, r31=0x40, r3=0x7}, len 5, writes in order plus r2 and r0 noise → pass=1, match_cnt=5, timeout=0.
- Same trace, fourth write r31=0x44 → fail=1 one cycle later, err_idx=3, err_reg=31, err_data=0x44, match_cnt=3.
- TIMEOUT=16, len 3, only two matching writes → fail=1, timeout=1, cycle_cnt=16, match_cnt=2.
- Final match on the same cycle cycle_cnt reaches TIMEOUT-1 → pass=1, timeout=0. Mismatch on that cycle → fail=1, timeout=0.
- After PASS, watched write r1=0x5 → overrun=1, pass remains 1. Then start with len 0 → pass=1, overrun=0.
- rst asserted mid-RUN after 2 matches → next cycle all outputs 0, state IDLE. Reloaded trace with a new start runs cleanly to pass.
